voice_scheduler: RTL and testbench

- Polyphonic voice allocator for the keyboard synth.
- Accepts key press/release events and assigns each pressed key to one of NUM_VOICES tone-generator voices.
- Time-multiplexes one shared key-to-frequency decoder to load each voice's frequency register.
- Sits between the key-event source (scanner or record playback) and the per-voice tone generators.

---
 rtl/keyboard_pkg.sv | 21 ++
 rtl/voice_select.sv | 67 ++++++
 rtl/voice_scheduler.sv | 174 +++++++++++++++++
 tb/tb_voice_scheduler.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keyboard_pkg.sv
// ---------------------------------------------------------------------------
// keyboard_pkg
// Shared constants and types for the keyboard synth voice path.
//   KEY_W         : key code width
//   FREQ_W        : frequency word width (Hz)
//   NUM_KEYS      : valid key codes are 0..NUM_KEYS-1
//   sched_state_t : voice scheduler FSM states
// ---------------------------------------------------------------------------
package keyboard_pkg;

    localparam int KEY_W    = 6;
    localparam int FREQ_W   = 32;
    localparam int NUM_KEYS = 48;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        LOOKUP = 2'd2
    } sched_state_t;

endpackage : keyboard_pkg

// File: rtl/voice_select.sv
// ---------------------------------------------------------------------------
// voice_select
// Combinational voice search used by the scheduler's SCAN step.
// Ports:
//   voice_active_i : per-voice gate
//   voice_key_i    : packed per-voice key codes, voice i at [i*KEY_W +: KEY_W]
//   ages_i         : packed per-voice ages, voice i at [i*AGE_W +: AGE_W]
//   key_i          : key being searched for
//   match_hit_o/match_idx_o : an active voice already holds key_i, and which
//   free_hit_o/free_idx_o   : an inactive voice exists, lowest index of them
//   oldest_idx_o            : active voice with the largest age (ties: lowest)
// ---------------------------------------------------------------------------
module voice_select #(
    parameter int NUM_VOICES = 4,
    parameter int KEY_W      = 6,
    parameter int AGE_W      = 2,
    parameter int IDX_W      = 2
) (
    input  logic [NUM_VOICES-1:0]       voice_active_i,
    input  logic [NUM_VOICES*KEY_W-1:0] voice_key_i,
    input  logic [NUM_VOICES*AGE_W-1:0] ages_i,
    input  logic [KEY_W-1:0]            key_i,
    output logic                        match_hit_o,
    output logic [IDX_W-1:0]            match_idx_o,
    output logic                        free_hit_o,
    output logic [IDX_W-1:0]            free_idx_o,
    output logic [IDX_W-1:0]            oldest_idx_o
);

    logic             oldest_found;
    logic [AGE_W-1:0] oldest_age;

    // Walking from the top index down lets the last hit win, which yields
    // the lowest matching / free index without a priority encoder chain.
    always_comb begin
        match_hit_o = 1'b0;
        match_idx_o = '0;
        free_hit_o  = 1'b0;
        free_idx_o  = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (voice_active_i[i] && (voice_key_i[i*KEY_W +: KEY_W] == key_i)) begin
                match_hit_o = 1'b1;
                match_idx_o = IDX_W'(i);
            end
            if (!voice_active_i[i]) begin
                free_hit_o = 1'b1;
                free_idx_o = IDX_W'(i);
            end
        end
    end

    // Strict '>' keeps the first (lowest-index) voice on an age tie.
    always_comb begin
        oldest_found = 1'b0;
        oldest_age   = '0;
        oldest_idx_o = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (voice_active_i[i] &&
                (!oldest_found || (ages_i[i*AGE_W +: AGE_W] > oldest_age))) begin
                oldest_found = 1'b1;
                oldest_age   = ages_i[i*AGE_W +: AGE_W];
                oldest_idx_o = IDX_W'(i);
            end
        end
    end

endmodule : voice_select

// File: rtl/voice_scheduler.sv
// ---------------------------------------------------------------------------
// voice_scheduler
// Polyphonic voice allocator: takes key press/release events and assigns
// pressed keys to NUM_VOICES tone-generator voices, loading each voice's
// frequency through one shared key-to-frequency decoder.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   ev_valid/ev_ready   : event handshake (ready only in IDLE)
//   ev_press, ev_key    : event type (1 = press) and key code
//   dec_key / dec_freq  : shared decoder request / combinational result
//   voice_active        : per-voice gate
//   voice_key           : per-voice key, voice i at [i*KEY_W +: KEY_W]
//   voice_freq          : per-voice frequency, voice i at [i*FREQ_W +: FREQ_W]
//   steal_pulse         : one cycle, an active voice was reassigned
//   drop_pulse          : one cycle, an event was discarded
// ---------------------------------------------------------------------------
module voice_scheduler #(
    parameter int NUM_VOICES = 4,
    parameter int KEY_W      = keyboard_pkg::KEY_W,
    parameter int FREQ_W     = keyboard_pkg::FREQ_W,
    parameter int NUM_KEYS   = keyboard_pkg::NUM_KEYS
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ev_valid,
    output logic                         ev_ready,
    input  logic                         ev_press,
    input  logic [KEY_W-1:0]             ev_key,
    output logic [KEY_W-1:0]             dec_key,
    input  logic [FREQ_W-1:0]            dec_freq,
    output logic [NUM_VOICES-1:0]        voice_active,
    output logic [NUM_VOICES*KEY_W-1:0]  voice_key,
    output logic [NUM_VOICES*FREQ_W-1:0] voice_freq,
    output logic                         steal_pulse,
    output logic                         drop_pulse
);

    import keyboard_pkg::*;

    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int AGE_W = IDX_W;
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(NUM_VOICES - 1);

    sched_state_t      state_q;
    logic              press_q;
    logic [KEY_W-1:0]  key_q;
    logic [IDX_W-1:0]  target_q;
    logic [KEY_W-1:0]  dec_key_q;
    logic              steal_q;
    logic              drop_q;

    logic [NUM_VOICES-1:0] voice_active_q;
    logic [KEY_W-1:0]      voice_key_q  [NUM_VOICES];
    logic [FREQ_W-1:0]     voice_freq_q [NUM_VOICES];
    logic [AGE_W-1:0]      age_q        [NUM_VOICES];
    // Ages after one aging step: active voices +1, saturating.
    logic [AGE_W-1:0]      age_d        [NUM_VOICES];

    logic [NUM_VOICES*AGE_W-1:0] ages_flat;

    logic             key_invalid;
    logic             match_hit;
    logic [IDX_W-1:0] match_idx;
    logic             free_hit;
    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] oldest_idx;

    assign key_invalid = (int'(key_q) >= NUM_KEYS);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
            assign age_d[gi] = (voice_active_q[gi] && (age_q[gi] != AGE_MAX))
                             ? age_q[gi] + AGE_W'(1) : age_q[gi];
            assign ages_flat[gi*AGE_W +: AGE_W]    = age_q[gi];
            assign voice_key[gi*KEY_W +: KEY_W]    = voice_key_q[gi];
            assign voice_freq[gi*FREQ_W +: FREQ_W] = voice_freq_q[gi];
        end
    endgenerate

    voice_select #(
        .NUM_VOICES (NUM_VOICES),
        .KEY_W      (KEY_W),
        .AGE_W      (AGE_W),
        .IDX_W      (IDX_W)
    ) u_select (
        .voice_active_i (voice_active_q),
        .voice_key_i    (voice_key),
        .ages_i         (ages_flat),
        .key_i          (key_q),
        .match_hit_o    (match_hit),
        .match_idx_o    (match_idx),
        .free_hit_o     (free_hit),
        .free_idx_o     (free_idx),
        .oldest_idx_o   (oldest_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            press_q        <= 1'b0;
            key_q          <= '0;
            target_q       <= '0;
            dec_key_q      <= '0;
            steal_q        <= 1'b0;
            drop_q         <= 1'b0;
            voice_active_q <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                voice_key_q[i]  <= '0;
                voice_freq_q[i] <= '0;
                age_q[i]        <= '0;
            end
        end else begin
            steal_q <= 1'b0;
            drop_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ev_valid) begin
                        press_q <= ev_press;
                        key_q   <= ev_key;
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    state_q <= IDLE;
                    if (key_invalid) begin
                        drop_q <= 1'b1;
                    end else if (press_q) begin
                        if (match_hit) begin
                            // Retrigger: no reload, just refresh the voice's age.
                            for (int i = 0; i < NUM_VOICES; i++) begin
                                age_q[i] <= (IDX_W'(i) == match_idx) ? '0 : age_d[i];
                            end
                        end else begin
                            target_q  <= free_hit ? free_idx : oldest_idx;
                            steal_q   <= !free_hit;
                            // The decoder only ever sees keys that are being loaded.
                            dec_key_q <= key_q;
                            state_q   <= LOOKUP;
                        end
                    end else if (match_hit) begin
                        // Key and frequency are kept so the tone generator
                        // can finish its release on the same pitch.
                        voice_active_q[match_idx] <= 1'b0;
                        age_q[match_idx]          <= '0;
                    end else begin
                        drop_q <= 1'b1;
                    end
                end
                LOOKUP: begin
                    state_q <= IDLE;
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        if (IDX_W'(i) == target_q) begin
                            voice_freq_q[i]   <= dec_freq;
                            voice_key_q[i]    <= key_q;
                            voice_active_q[i] <= 1'b1;
                            age_q[i]          <= '0;
                        end else begin
                            age_q[i] <= age_d[i];
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ev_ready     = (state_q == IDLE);
    assign dec_key      = dec_key_q;
    assign voice_active = voice_active_q;
    assign steal_pulse  = steal_q;
    assign drop_pulse   = drop_q;

endmodule : voice_scheduler

// File: tb/tb_voice_scheduler.sv
// ---------------------------------------------------------------------------
// tb_voice_scheduler
// Directed scoreboard bench for voice_scheduler. Stimulus pushes the
// hand-derived expected voice state for each event; a monitor pops and
// compares when the scheduler returns to ready after that event.
// ---------------------------------------------------------------------------
module tb_voice_scheduler;

    localparam int NV = 4;
    localparam int KW = 6;
    localparam int FW = 32;

    localparam int A_LOAD   = 0;
    localparam int A_RETRIG = 1;
    localparam int A_REL    = 2;
    localparam int A_DROP   = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             ev_valid = 1'b0;
    logic             ev_ready;
    logic             ev_press = 1'b0;
    logic [KW-1:0]    ev_key = '0;
    logic [KW-1:0]    dec_key;
    logic [FW-1:0]    dec_freq;
    logic [NV-1:0]    voice_active;
    logic [NV*KW-1:0] voice_key;
    logic [NV*FW-1:0] voice_freq;
    logic             steal_pulse;
    logic             drop_pulse;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    voice_scheduler #(
        .NUM_VOICES (NV),
        .KEY_W      (KW),
        .FREQ_W     (FW),
        .NUM_KEYS   (48)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_press     (ev_press),
        .ev_key       (ev_key),
        .dec_key      (dec_key),
        .dec_freq     (dec_freq),
        .voice_active (voice_active),
        .voice_key    (voice_key),
        .voice_freq   (voice_freq),
        .steal_pulse  (steal_pulse),
        .drop_pulse   (drop_pulse)
    );

    // Equal-temperament table (key 0 = C3), rounded down to whole Hz.
    function automatic logic [FW-1:0] freq_of(input logic [KW-1:0] k);
        case (k)
            6'd0:    freq_of = 32'd130;
            6'd4:    freq_of = 32'd164;
            6'd9:    freq_of = 32'd220;
            6'd12:   freq_of = 32'd261;
            6'd21:   freq_of = 32'd440;
            6'd24:   freq_of = 32'd523;
            6'd33:   freq_of = 32'd880;
            6'd36:   freq_of = 32'd1046;
            6'd47:   freq_of = 32'd1975;
            default: freq_of = 32'd1000 + {26'd0, k};
        endcase
    endfunction

    assign dec_freq = freq_of(dec_key);

    typedef struct {
        string         name;
        logic [NV-1:0] active;
        logic [NV*KW-1:0] keys;
        logic [NV*FW-1:0] freqs;
        int            steal;
        int            drop;
        int            lat;
        logic [KW-1:0] dec_end;
        logic          chk_lookup;
        logic [KW-1:0] dec_lookup;
    } exp_t;

    exp_t exp_q[$];

    logic [NV-1:0]    sh_active;
    logic [NV*KW-1:0] sh_keys;
    logic [NV*FW-1:0] sh_freqs;
    logic [KW-1:0]    sh_dec;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    task automatic clear_shadow();
        sh_active = '0;
        sh_keys   = '0;
        sh_freqs  = '0;
        sh_dec    = '0;
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_ready"},  128'(ev_ready), 128'(1));
        check({tag, "_active"}, 128'(voice_active), 128'(0));
        check({tag, "_keys"},   128'(voice_key), 128'(0));
        check({tag, "_freqs"},  128'(voice_freq), 128'(0));
        check({tag, "_deckey"}, 128'(dec_key), 128'(0));
        check({tag, "_pulses"}, 128'({steal_pulse, drop_pulse}), 128'(0));
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("drain_timeout", 128'(exp_q.size()), 128'(0));
    endtask

    task automatic release_reset(input string tag);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_shadow();
        @(posedge clk);
        #1;
        chk_reset(tag);
    endtask

    task automatic do_reset(input string tag);
        wait_idle();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        release_reset(tag);
    endtask

    // Called at posedge+1; issues one event and returns one cycle after accept.
    task automatic send(input string nm, input logic p, input logic [KW-1:0] k,
                        input int act, input int tgt, input int steal);
        exp_t e;
        int guard = 0;
        while (!ev_ready && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (!ev_ready) begin
            check({nm, "_ready_timeout"}, 128'(ev_ready), 128'(1));
            return;
        end
        e.lat = 2;
        case (act)
            A_LOAD: begin
                sh_active[tgt]           = 1'b1;
                sh_keys[tgt*KW +: KW]    = k;
                sh_freqs[tgt*FW +: FW]   = freq_of(k);
                sh_dec                   = k;
                e.lat                    = 3;
            end
            A_REL:   sh_active[tgt] = 1'b0;
            default: ;
        endcase
        e.name       = nm;
        e.active     = sh_active;
        e.keys       = sh_keys;
        e.freqs      = sh_freqs;
        e.steal      = steal;
        e.drop       = (act == A_DROP) ? 1 : 0;
        e.dec_end    = sh_dec;
        e.chk_lookup = (act == A_LOAD);
        e.dec_lookup = k;
        exp_q.push_back(e);
        ev_valid = 1'b1;
        ev_press = p;
        ev_key   = k;
        @(posedge clk);
        #1;
        ev_valid = 1'b0;
    endtask

    // Monitor / scoreboard.
    initial begin
        bit in_flight = 1'b0;
        int cyc = 0;
        int steal_n = 0;
        int drop_n = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_flight = 1'b0;
                exp_q.delete();
            end else begin
                if (in_flight) begin
                    cyc++;
                    if (steal_pulse) steal_n++;
                    if (drop_pulse)  drop_n++;
                    if (cyc == 2 && exp_q.size() > 0 && exp_q[0].chk_lookup)
                        check({exp_q[0].name, "_dec_lookup"}, 128'(dec_key), 128'(exp_q[0].dec_lookup));
                    if (ev_ready || cyc > 8) begin
                        in_flight = 1'b0;
                        if (exp_q.size() == 0) begin
                            check("unexpected_completion", 128'(1), 128'(0));
                        end else begin
                            e = exp_q.pop_front();
                            check({e.name, "_latency"}, 128'(cyc), 128'(e.lat));
                            check({e.name, "_active"},  128'(voice_active), 128'(e.active));
                            check({e.name, "_keys"},    128'(voice_key), 128'(e.keys));
                            check({e.name, "_freqs"},   128'(voice_freq), 128'(e.freqs));
                            check({e.name, "_steal"},   128'(steal_n), 128'(e.steal));
                            check({e.name, "_drop"},    128'(drop_n), 128'(e.drop));
                            check({e.name, "_dec_end"}, 128'(dec_key), 128'(e.dec_end));
                            $display("txn %-14s active=%b freqs=%0d,%0d,%0d,%0d steal=%0d drop=%0d",
                                     e.name, voice_active,
                                     voice_freq[3*FW +: FW], voice_freq[2*FW +: FW],
                                     voice_freq[1*FW +: FW], voice_freq[0*FW +: FW],
                                     steal_n, drop_n);
                        end
                    end
                end
                if (ev_valid && ev_ready) begin
                    in_flight = 1'b1;
                    cyc       = 0;
                    steal_n   = 0;
                    drop_n    = 0;
                end
            end
        end
    end

    initial begin
        clear_shadow();
        #1;
        chk_reset("reset_async");
        release_reset("reset0");

        // Single press
        send("press21", 1'b1, 6'd21, A_LOAD, 0, 0);

        // Fill, then steal the oldest twice
        do_reset("reset_fill");
        send("fill0",   1'b1, 6'd0,  A_LOAD, 0, 0);
        send("fill12",  1'b1, 6'd12, A_LOAD, 1, 0);
        send("fill24",  1'b1, 6'd24, A_LOAD, 2, 0);
        send("fill36",  1'b1, 6'd36, A_LOAD, 3, 0);
        send("steal4",  1'b1, 6'd4,  A_LOAD, 0, 1);
        send("steal47", 1'b1, 6'd47, A_LOAD, 1, 1);

        // Retrigger refreshes voice 0, so the later steal takes voice 1
        do_reset("reset_retrig");
        send("rt_p21",    1'b1, 6'd21, A_LOAD,   0, 0);
        send("rt_p9",     1'b1, 6'd9,  A_LOAD,   1, 0);
        send("rt_again",  1'b1, 6'd21, A_RETRIG, 0, 0);
        send("rt_p0",     1'b1, 6'd0,  A_LOAD,   2, 0);
        send("rt_p12",    1'b1, 6'd12, A_LOAD,   3, 0);
        send("rt_steal",  1'b1, 6'd24, A_LOAD,   1, 1);

        // Releases and drops
        send("rel21",     1'b0, 6'd21, A_REL,  0, 0);
        send("rel33_nh",  1'b0, 6'd33, A_DROP, 0, 0);
        send("press50",   1'b1, 6'd50, A_DROP, 0, 0);
        send("refill33",  1'b1, 6'd33, A_LOAD, 0, 0);

        // Reset during LOOKUP
        do_reset("reset_abort");
        send("abort21", 1'b1, 6'd21, A_LOAD, 0, 0);
        @(posedge clk);
        #1;
        check("abort_in_lookup_deckey", 128'(dec_key), 128'(21));
        rst_n = 1'b0;
        #1;
        chk_reset("abort_reset");
        release_reset("abort_release");
        send("after_abort21", 1'b1, 6'd21, A_LOAD, 0, 0);

        wait_idle();
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_voice_scheduler
